// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer for the subordinate guard. It isolates the guard, pulses the
// subordinate reset, waits for an acknowledge, retries a bounded number of times and latches a failure.
module slv_guard_rst_ctrl #(
  parameter int RstHoldCycles = 16,
  parameter int AckTimeout    = 256,
  parameter int MaxRetries    = 3,
  parameter int CntWidth      = 16,
  localparam int RetryWidth   = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ctrl_ena_i,
  input  logic                  rst_req_i,
  input  logic                  rst_ack_i,
  input  logic                  sw_clear_i,
  output logic                  guard_ena_o,
  output logic                  rst_stat_o,
  output logic                  slv_rst_no,
  output logic                  busy_o,
  output logic                  fail_o,
  output logic [RetryWidth-1:0] retry_cnt_o,
  output logic [7:0]            rst_count_o
);

  typedef enum logic [2:0] {
    IDLE, ISOLATE, ASSERT, WAIT_ACK, CLEAR, FAILED
  } state_e;

  localparam logic [CntWidth-1:0]   HoldLoad = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0]   AckLoad  = CntWidth'(AckTimeout - 1);
  localparam logic [CntWidth-1:0]   CntOne   = CntWidth'(1);
  localparam logic [RetryWidth-1:0] RetryMax = RetryWidth'(MaxRetries);
  localparam logic [RetryWidth-1:0] RetryOne = RetryWidth'(1);

  state_e              state;
  logic [CntWidth-1:0] cnt;

  // NOTE: the reset branch lives inside the clocked block, so it only takes effect on a clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      guard_ena_o <= 1'b0;
      rst_stat_o  <= 1'b0;
      slv_rst_no  <= 1'b1;
      busy_o      <= 1'b0;
      fail_o      <= 1'b0;
      retry_cnt_o <= '0;
      rst_count_o <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every output a clean register of the current state.
      case (state)
        IDLE: begin
          guard_ena_o <= ctrl_ena_i;
          if (rst_req_i && ctrl_ena_i) begin
            state       <= ISOLATE;
            guard_ena_o <= 1'b0;
            retry_cnt_o <= '0;
            busy_o      <= 1'b1;
          end
        end

        ISOLATE: begin
          state      <= ASSERT;
          cnt        <= HoldLoad;
          slv_rst_no <= 1'b0;
          // Incidents are counted once, not per retry.
          if (rst_count_o != 8'hFF) rst_count_o <= rst_count_o + 8'd1;
        end

        ASSERT: begin
          if (cnt == '0) begin
            state      <= WAIT_ACK;
            slv_rst_no <= 1'b1;
            cnt        <= AckLoad;
          end else begin
            cnt <= cnt - CntOne;
          end
        end

        WAIT_ACK: begin
          // An acknowledge on the final timeout cycle still counts as success.
          if (rst_ack_i) begin
            state      <= CLEAR;
            rst_stat_o <= 1'b1;
          end else if (cnt == '0) begin
            slv_rst_no <= 1'b0;
            if (retry_cnt_o < RetryMax) begin
              state       <= ASSERT;
              retry_cnt_o <= retry_cnt_o + RetryOne;
              cnt         <= HoldLoad;
            end else begin
              state  <= FAILED;
              fail_o <= 1'b1;
            end
          end else begin
            cnt <= cnt - CntOne;
          end
        end

        CLEAR: begin
          if (!rst_req_i) begin
            state       <= IDLE;
            rst_stat_o  <= 1'b0;
            guard_ena_o <= ctrl_ena_i;
            busy_o      <= 1'b0;
          end
        end

        FAILED: begin
          // Subordinate stays in reset until software acknowledges.
          if (sw_clear_i) begin
            state       <= IDLE;
            fail_o      <= 1'b0;
            retry_cnt_o <= '0;
            slv_rst_no  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Bench for slv_guard_rst_ctrl: a literal nominal table, then expected traces built
// per incident from the timing rules (directed and random), plus reset and saturation sequences.
module tb_slv_guard_rst_ctrl;

  localparam int H  = 4;
  localparam int A  = 8;
  localparam int M  = 2;
  localparam int RW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst_n, ena, req, ack, clr;
  logic          guard_ena, rst_stat, slv_rst_n, busy, fail;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    rst_count;

  // One cycle: inputs driven during a cycle, outputs expected right after its closing edge.
  typedef struct packed {
    logic          ena, req, ack, clr;
    logic          g, st, sn, b, f;
    logic [RW-1:0] r;
    logic [7:0]    cnt;
  } vec_t;

  localparam logic [14:0] ResetOuts = {5'b00100, 2'd0, 8'd0};

  int   n_checks;
  int   n_fail;
  int   model_cnt;
  int   model_r;
  vec_t trace[$];
  vec_t tbl[16];

  slv_guard_rst_ctrl #(
    .RstHoldCycles(H),
    .AckTimeout   (A),
    .MaxRetries   (M),
    .CntWidth     (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ctrl_ena_i (ena),
    .rst_req_i  (req),
    .rst_ack_i  (ack),
    .sw_clear_i (clr),
    .guard_ena_o(guard_ena),
    .rst_stat_o (rst_stat),
    .slv_rst_no (slv_rst_n),
    .busy_o     (busy),
    .fail_o     (fail),
    .retry_cnt_o(retry_cnt),
    .rst_count_o(rst_count)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] outs();
    return {guard_ena, rst_stat, slv_rst_n, busy, fail, retry_cnt, rst_count};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got g/st/sn/b/f=%b retry=%0d count=%0d, expected g/st/sn/b/f=%b retry=%0d count=%0d",
               name, act[14:10], act[9:8], act[7:0], exp[14:10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string name);
    ena = v.ena;
    req = v.req;
    ack = v.ack;
    clr = v.clr;
    step();
    check(name, outs(), v[14:0]);
  endtask

  task automatic push(input logic e, input logic rq, input logic ak, input logic cl,
                      input logic g, input logic st, input logic sn, input logic b, input logic f);
    vec_t v;
    v.ena = e;  v.req = rq; v.ack = ak; v.clr = cl;
    v.g   = g;  v.st  = st; v.sn  = sn; v.b   = b; v.f = f;
    v.r   = RW'(model_r);
    v.cnt = 8'(model_cnt);
    trace.push_back(v);
  endtask

  task automatic run_trace(input string name);
    while (trace.size() > 0) apply(trace.pop_front(), name);
  endtask

  // One incident seen from IDLE. ack_att = attempt that gets acknowledged (> M: never),
  // ack_d = WAIT_ACK cycle on which ack is seen, extra = cycles the request lingers after
  // status, hold = cycles spent in FAILED before clear, e_end = enable when returning to IDLE.
  task automatic gen_incident(input logic e, input int ack_att, input int ack_d,
                              input int extra, input int hold, input logic e_end);
    if (!e) begin
      push(1'b0, 1'b1, rb(), rb(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(1'b0, 1'b1, rb(), rb(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      return;
    end
    model_r = 0;
    push(1'b1, 1'b1, rb(), rb(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    for (int a = 0; a <= M; a++) begin
      model_r = a;
      for (int i = 0; i < H; i++)
        push(rb(), rb(), (i == 0) ? 1'b0 : rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (a == ack_att) begin
        for (int i = 0; i <= ack_d; i++)
          push(rb(), rb(), (i == 0) ? rb() : 1'b0, rb(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push(rb(), rb(), 1'b1, rb(), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < extra; i++)
          push(rb(), 1'b1, rb(), rb(), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push(e_end, 1'b0, 1'b0, rb(), e_end, 1'b0, 1'b1, 1'b0, 1'b0);
        return;
      end
      for (int i = 0; i < A; i++)
        push(rb(), rb(), (i == 0) ? rb() : 1'b0, rb(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    model_r = M;
    push(rb(), rb(), 1'b0, rb(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < hold; i++)
      push(rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    model_r = 0;
    push(rb(), rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(e_end, 1'b0, 1'b0, 1'b0, e_end, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_cnt = 0;
    model_r   = 0;
    rst_n = 1'b0; ena = 1'b0; req = 1'b0; ack = 1'b0; clr = 1'b0;
    step();
    step();
    check("reset_state", outs(), ResetOuts);
    rst_n = 1'b1;

    // {ena,req,ack,clr}, {g,st,sn,b,f}, retry, count
    tbl[0]  = {4'b1000, 5'b10100, 2'd0, 8'd0};  // idle, guard follows enable
    tbl[1]  = {4'b1100, 5'b00110, 2'd0, 8'd0};  // isolate
    tbl[2]  = {4'b1100, 5'b00010, 2'd0, 8'd1};  // hold low x4
    tbl[3]  = {4'b1100, 5'b00010, 2'd0, 8'd1};
    tbl[4]  = {4'b1100, 5'b00010, 2'd0, 8'd1};
    tbl[5]  = {4'b1100, 5'b00010, 2'd0, 8'd1};
    tbl[6]  = {4'b1100, 5'b00110, 2'd0, 8'd1};  // waiting for ack
    tbl[7]  = {4'b1100, 5'b00110, 2'd0, 8'd1};
    tbl[8]  = {4'b1100, 5'b00110, 2'd0, 8'd1};
    tbl[9]  = {4'b1100, 5'b00110, 2'd0, 8'd1};
    tbl[10] = {4'b1110, 5'b01110, 2'd0, 8'd1};  // ack 3 cycles after release
    tbl[11] = {4'b1000, 5'b10100, 2'd0, 8'd1};  // request dropped, back to idle
    tbl[12] = {4'b0100, 5'b00100, 2'd0, 8'd1};  // request while disabled is ignored
    tbl[13] = {4'b0100, 5'b00100, 2'd0, 8'd1};
    tbl[14] = {4'b1001, 5'b10100, 2'd0, 8'd1};  // clear outside FAILED is ignored
    tbl[15] = {4'b1000, 5'b10100, 2'd0, 8'd1};
    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("nominal_row%0d", i));
    model_cnt = 1;

    gen_incident(1'b1, 1, 2, 0, 0, 1'b1);
    run_trace("single_retry");
    gen_incident(1'b1, M + 1, 0, 0, 3, 1'b1);
    run_trace("exhausted_retries");
    gen_incident(1'b1, 0, A - 1, 5, 0, 1'b1);
    run_trace("ack_timeout_collision");
    gen_incident(1'b1, 0, 1, 0, 0, 1'b0);
    run_trace("enable_dropped");
    gen_incident(1'b0, 0, 0, 0, 0, 1'b1);
    run_trace("disabled_request");

    for (int n = 0; n < 30; n++) begin
      gen_incident(($urandom_range(0, 3) != 0), $urandom_range(0, M + 1), $urandom_range(0, A - 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), rb());
      run_trace($sformatf("random_incident%0d", n));
    end

    ena = 1'b1; req = 1'b1; ack = 1'b0; clr = 1'b0;
    step();
    step();
    step();
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    check("assert_before_reset", outs(), {5'b00010, 2'd0, 8'(model_cnt)});
    rst_n = 1'b0;
    step();
    check("reset_during_assert", outs(), ResetOuts);
    rst_n = 1'b1; req = 1'b0;
    step();
    check("idle_after_reset", outs(), {5'b10100, 2'd0, 8'd0});
    model_cnt = 0;
    model_r   = 0;

    for (int n = 0; n < 260; n++) begin
      gen_incident(1'b1, 0, 0, 0, 0, 1'b1);
      run_trace("saturation");
    end
    check("rst_count_saturated", {7'd0, rst_count}, 15'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
